// File: rtl/ahb_router_ds.sv
// AHB-Lite 1:N router with address decode, registered data-phase select and a built-in error (default) slave.
// Latency: mapped slaves add zero wait states; an unmapped NONSEQ/SEQ costs one wait state (two-cycle ERROR).
// Backpressure: the data-phase owner's HREADYOUT is returned to the master; select only advances when hready is high.
module ahb_router_ds #(
  parameter int slv_c = 4,
  parameter int aw    = 32,
  parameter int dw    = 32,
  parameter int ecw   = 8
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic [slv_c-1:0][aw-1:0]     haddr_base,
  input  logic [slv_c-1:0][aw-1:0]     haddr_mask,
  input  logic [aw-1:0]                haddr,
  input  logic [dw-1:0]                hwdata,
  input  logic                         hwrite,
  input  logic [1:0]                   htrans,
  input  logic [2:0]                   hsize,
  input  logic [2:0]                   hburst,
  output logic [dw-1:0]                hrdata,
  output logic [1:0]                   hresp,
  output logic                         hready,
  output logic [slv_c-1:0][aw-1:0]     haddr_s,
  output logic [slv_c-1:0][dw-1:0]     hwdata_s,
  output logic [slv_c-1:0]             hwrite_s,
  output logic [slv_c-1:0][1:0]        htrans_s,
  output logic [slv_c-1:0][2:0]        hsize_s,
  output logic [slv_c-1:0][2:0]        hburst_s,
  output logic [slv_c-1:0]             hsel_s,
  input  logic [slv_c-1:0][dw-1:0]     hrdata_s,
  input  logic [slv_c-1:0][1:0]        hresp_s,
  input  logic [slv_c-1:0]             hready_s,
  output logic [ecw-1:0]               err_cnt,
  output logic [aw-1:0]                err_addr
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  logic [slv_c-1:0] match;
  logic             def_sel;
  logic [slv_c:0]   dsel_q, dsel_d;
  ds_state_t        ds_state_q, ds_state_d;
  logic [ecw-1:0]   err_cnt_q, err_cnt_d;
  logic [aw-1:0]    err_addr_q, err_addr_d;
  logic             ds_ready;
  logic [1:0]       ds_resp;
  logic             new_err;

  // Window match per slave: masked address equals the programmed base.
  always_comb begin
    match = '0;
    for (int i = 0; i < slv_c; i++) begin
      match[i] = ((haddr & haddr_mask[i]) == haddr_base[i]);
    end
  end

  // Priority select: lowest matching index wins; independent of htrans.
  always_comb begin
    hsel_s = '0;
    for (int i = slv_c - 1; i >= 0; i--) begin
      if (match[i]) begin
        hsel_s    = '0;
        hsel_s[i] = 1'b1;
      end
    end
  end

  assign def_sel = ~|match;

  // Broadcast the master's address-phase and write-data signals to every slave.
  always_comb begin
    for (int i = 0; i < slv_c; i++) begin
      haddr_s[i]  = haddr;
      hwdata_s[i] = hwdata;
      hwrite_s[i] = hwrite;
      htrans_s[i] = htrans;
      hsize_s[i]  = hsize;
      hburst_s[i] = hburst;
    end
  end

  // Data-phase owner advances only when the current data phase completes.
  always_comb begin
    dsel_d = dsel_q;
    if (hready) begin
      dsel_d = {def_sel, hsel_s};
    end
  end

  // Data-phase select register; all-zero means no transfer is owed.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dsel_q <= '0;
    end else begin
      dsel_q <= dsel_d;
    end
  end

  // Default slave outputs are a pure function of its state (Moore).
  assign ds_ready = (ds_state_q != DS_ERR1);
  assign ds_resp  = (ds_state_q == DS_IDLE) ? RESP_OKAY : RESP_ERROR;

  // Response mux: route the owner's response; no owner reads as an idle OKAY.
  always_comb begin
    hrdata = '0;
    hresp  = RESP_OKAY;
    hready = 1'b1;
    for (int i = 0; i < slv_c; i++) begin
      if (dsel_q[i]) begin
        hrdata = hrdata_s[i];
        hresp  = hresp_s[i];
        hready = hready_s[i];
      end
    end
    if (dsel_q[slv_c]) begin
      hrdata = '0;
      hresp  = ds_resp;
      hready = ds_ready;
    end
  end

  // An accepted active transfer (NONSEQ/SEQ) that decodes to no slave.
  assign new_err = hready & def_sel & htrans[1];

  // Default slave next state, error counter and faulting address capture.
  always_comb begin
    ds_state_d = ds_state_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    case (ds_state_q)
      DS_IDLE: begin
        if (new_err) begin
          ds_state_d = DS_ERR1;
          err_addr_d = haddr;
        end
      end
      DS_ERR1: begin
        ds_state_d = DS_ERR2;
      end
      DS_ERR2: begin
        if (err_cnt_q != {ecw{1'b1}}) begin
          err_cnt_d = err_cnt_q + {{(ecw-1){1'b0}}, 1'b1};
        end
        if (new_err) begin
          ds_state_d = DS_ERR1;
          err_addr_d = haddr;
        end else begin
          ds_state_d = DS_IDLE;
        end
      end
      default: begin
        ds_state_d = DS_IDLE;
      end
    endcase
  end

  // Default slave state and error status registers.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      ds_state_q <= DS_IDLE;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      ds_state_q <= ds_state_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_ahb_router_ds.sv
// Directed bench for ahb_router_ds: decode, wait-state hold, default-slave ERROR, reset, counter saturation.
// Latency: checks one data phase after each address phase.
// Backpressure: slave 1 HREADYOUT is driven low to exercise select hold.
module tb_ahb_router_ds;

  localparam int SLV = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int ECW = 8;

  logic                     hclk;
  logic                     hreset;
  logic [SLV-1:0][AW-1:0]   haddr_base;
  logic [SLV-1:0][AW-1:0]   haddr_mask;
  logic [AW-1:0]            haddr;
  logic [DW-1:0]            hwdata;
  logic                     hwrite;
  logic [1:0]               htrans;
  logic [2:0]               hsize;
  logic [2:0]               hburst;
  logic [DW-1:0]            hrdata;
  logic [1:0]               hresp;
  logic                     hready;
  logic [SLV-1:0][AW-1:0]   haddr_s;
  logic [SLV-1:0][DW-1:0]   hwdata_s;
  logic [SLV-1:0]           hwrite_s;
  logic [SLV-1:0][1:0]      htrans_s;
  logic [SLV-1:0][2:0]      hsize_s;
  logic [SLV-1:0][2:0]      hburst_s;
  logic [SLV-1:0]           hsel_s;
  logic [SLV-1:0][DW-1:0]   hrdata_s;
  logic [SLV-1:0][1:0]      hresp_s;
  logic [SLV-1:0]           hready_s;
  logic [ECW-1:0]           err_cnt;
  logic [AW-1:0]            err_addr;

  int vectors;
  int miscompares;

  ahb_router_ds #(.slv_c(SLV), .aw(AW), .dw(DW), .ecw(ECW)) dut (
    .hclk(hclk), .hreset(hreset),
    .haddr_base(haddr_base), .haddr_mask(haddr_mask),
    .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hburst(hburst),
    .hrdata(hrdata), .hresp(hresp), .hready(hready),
    .haddr_s(haddr_s), .hwdata_s(hwdata_s), .hwrite_s(hwrite_s), .htrans_s(htrans_s),
    .hsize_s(hsize_s), .hburst_s(hburst_s), .hsel_s(hsel_s),
    .hrdata_s(hrdata_s), .hresp_s(hresp_s), .hready_s(hready_s),
    .err_cnt(err_cnt), .err_addr(err_addr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let inputs be driven.
  task automatic tick();
    @(posedge hclk);
    #2;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    hreset      = 1'b1;
    haddr_base  = {32'h6000_0000, 32'h5000_0000, 32'h4000_0000, 32'h0000_0000};
    haddr_mask  = {4{32'hF000_0000}};
    haddr       = 32'h9000_0000;
    hwdata      = 32'h1234_5678;
    hwrite      = 1'b0;
    htrans      = 2'b00;
    hsize       = 3'b010;
    hburst      = 3'b000;
    hrdata_s    = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'hAAAA_0000};
    hresp_s     = '0;
    hready_s    = '1;

    // Reset state.
    #3;
    chk("rst_hready", hready, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_hsel", hsel_s, 0);
    tick();
    hreset = 1'b0;
    tick();
    tick();
    #1;
    chk("idle_hready", hready, 1);
    chk("idle_hresp", hresp, 0);
    chk("idle_hrdata", hrdata, 0);
    chk("idle_errcnt", err_cnt, 0);

    // Mapped NONSEQ read to slave 1.
    haddr  = 32'h4000_0010;
    htrans = 2'b10;
    #1;
    chk("s1_hsel", hsel_s, 4'b0010);
    chk("s1_haddr_bcast", haddr_s[1], 32'h4000_0010);
    chk("s1_htrans_bcast", htrans_s[3], 2'b10);
    tick();
    haddr  = 32'h9000_0000;
    htrans = 2'b00;
    #1;
    chk("s1_hrdata", hrdata, 32'hCAFE_F00D);
    chk("s1_hresp", hresp, 0);
    chk("s1_hready", hready, 1);

    // Slave 1 stretches its data phase while slave 2 waits in address phase.
    tick();
    haddr  = 32'h4000_0020;
    htrans = 2'b10;
    tick();
    hready_s[1] = 1'b0;
    haddr       = 32'h5000_0000;
    #1;
    chk("ws1_hsel", hsel_s, 4'b0100);
    chk("ws1_hready", hready, 0);
    chk("ws1_hrdata", hrdata, 32'hCAFE_F00D);
    tick();
    #1;
    chk("ws2_hready", hready, 0);
    chk("ws2_hrdata", hrdata, 32'hCAFE_F00D);
    tick();
    hready_s[1] = 1'b1;
    #1;
    chk("ws3_hready", hready, 1);
    chk("ws3_hrdata", hrdata, 32'hCAFE_F00D);
    tick();
    haddr  = 32'h9000_0000;
    htrans = 2'b00;
    #1;
    chk("s2_hrdata", hrdata, 32'h2222_2222);

    // Single unmapped NONSEQ.
    tick();
    haddr  = 32'h9000_0004;
    htrans = 2'b10;
    #1;
    chk("um_hsel", hsel_s, 0);
    tick();
    haddr  = 32'h9000_0000;
    htrans = 2'b00;
    #1;
    chk("um_err1_hready", hready, 0);
    chk("um_err1_hresp", hresp, 2'b01);
    chk("um_err_addr", err_addr, 32'h9000_0004);
    tick();
    #1;
    chk("um_err2_hready", hready, 1);
    chk("um_err2_hresp", hresp, 2'b01);
    tick();
    #1;
    chk("um_done_hresp", hresp, 0);
    chk("um_errcnt", err_cnt, 1);

    // Back-to-back unmapped NONSEQ transfers.
    haddr  = 32'h9000_0008;
    htrans = 2'b10;
    tick();
    haddr  = 32'h9000_000C;
    #1;
    chk("bb_a_err1_hready", hready, 0);
    chk("bb_a_err1_hresp", hresp, 2'b01);
    tick();
    #1;
    chk("bb_a_err2_hready", hready, 1);
    chk("bb_a_err2_hresp", hresp, 2'b01);
    tick();
    haddr  = 32'h9000_0000;
    htrans = 2'b00;
    #1;
    chk("bb_b_err1_hready", hready, 0);
    chk("bb_b_err1_hresp", hresp, 2'b01);
    chk("bb_errcnt_mid", err_cnt, 2);
    chk("bb_err_addr", err_addr, 32'h9000_000C);
    tick();
    #1;
    chk("bb_b_err2_hready", hready, 1);
    chk("bb_b_err2_hresp", hresp, 2'b01);
    tick();
    #1;
    chk("bb_errcnt", err_cnt, 3);

    // IDLE and BUSY to unmapped addresses: zero-wait OKAY, no count.
    tick();
    #1;
    chk("idle_um_hresp", hresp, 0);
    htrans = 2'b01;
    tick();
    #1;
    chk("busy_um_hready", hready, 1);
    chk("busy_um_hresp", hresp, 0);
    chk("busy_um_errcnt", err_cnt, 3);

    // Asynchronous reset in the middle of an ERROR response.
    haddr  = 32'h9000_0010;
    htrans = 2'b10;
    tick();
    htrans = 2'b00;
    haddr  = 32'h9000_0000;
    #1;
    chk("rerr_hready", hready, 0);
    hreset = 1'b1;
    #1;
    chk("arst_hready", hready, 1);
    chk("arst_hresp", hresp, 0);
    chk("arst_errcnt", err_cnt, 0);
    chk("arst_err_addr", err_addr, 0);
    #1;
    hreset = 1'b0;
    tick();
    haddr  = 32'h0000_0100;
    htrans = 2'b10;
    #1;
    chk("post_hsel", hsel_s, 4'b0001);
    tick();
    htrans = 2'b00;
    haddr  = 32'h9000_0000;
    #1;
    chk("post_hrdata", hrdata, 32'hAAAA_0000);
    chk("post_hready", hready, 1);
    chk("post_hresp", hresp, 0);

    // Continuous unmapped NONSEQ stream until the counter saturates.
    tick();
    haddr  = 32'h9000_0020;
    htrans = 2'b10;
    repeat (509) tick();
    #1;
    chk("sat_254", err_cnt, 8'hFE);
    repeat (2) tick();
    #1;
    chk("sat_255", err_cnt, 8'hFF);
    repeat (4) tick();
    htrans = 2'b00;
    repeat (3) tick();
    #1;
    chk("sat_hold", err_cnt, 8'hFF);
    chk("sat_hresp", hresp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
